dcache_direct: RTL and testbench

Direct-mapped, write-back, write-allocate data cache: the responder side of the stage-3 data-memory request interface. It accepts word-aligned address, write data, read enable and 4-bit byte write enables from the stage-3 memory-access logic and returns the raw 32-bit word. It raises `stall` on a miss while it writes back a dirty line and refills over a 128-bit ready/valid memory port. Byte/half alignment and sign extension stay in stage 3; this block only deals in whole, byte-masked words.

---
 rtl/dcache_direct.sv | 151 +++++++++++++++
 tb/tb_dcache_direct.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dcache_direct.sv
// dcache_direct: direct-mapped, write-back, write-allocate data cache with 16 B (4-word) lines.
// Ports: clk/reset (sync, active-high); CPU side addr/din/re/we in, dout/stall out;
//   memory side 128-bit ready/valid line request (mem_req_*), one-cycle refill (mem_resp_*);
//   hit_count/miss_count wrapping statistics.
module dcache_direct #(
  parameter int LINES = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [31:0]  addr,
  input  logic [31:0]  din,
  input  logic         re,
  input  logic [3:0]   we,
  output logic [31:0]  dout,
  output logic         stall,
  output logic         mem_req_valid,
  input  logic         mem_req_ready,
  output logic         mem_req_rw,
  output logic [27:0]  mem_req_addr,
  output logic [127:0] mem_req_data,
  input  logic         mem_resp_valid,
  input  logic [127:0] mem_resp_data,
  output logic [31:0]  hit_count,
  output logic [31:0]  miss_count
);
  localparam int IDX  = $clog2(LINES);
  localparam int TAGW = 28 - IDX;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WB   = 2'd1;
  localparam logic [1:0] S_RF   = 2'd2;
  localparam logic [1:0] S_WAIT = 2'd3;

  logic [1:0]       state;
  logic [LINES-1:0] valid_q;
  logic [LINES-1:0] dirty_q;
  logic [TAGW-1:0]  tag_q  [LINES];
  logic [127:0]     data_q [LINES];

  // Miss request captured in IDLE; drives all later miss handling.
  logic [27:0] req_line;
  logic [1:0]  req_off;
  logic [31:0] req_din;
  logic [3:0]  req_we;
  logic        req_re;

  logic [1:0]      cur_off;
  logic [IDX-1:0]  cur_idx;
  logic [TAGW-1:0] cur_tag;
  logic [IDX-1:0]  req_idx;
  logic [TAGW-1:0] req_tag;
  logic            is_write;
  logic            access;
  logic            hit;
  logic [31:0]     cur_word;
  logic [127:0]    refill_line;
  logic            unused_addr_bits;

  assign cur_off  = addr[3:2];
  assign cur_idx  = addr[4+IDX-1:4];
  assign cur_tag  = addr[31:4+IDX];
  assign req_idx  = req_line[IDX-1:0];
  assign req_tag  = req_line[27:IDX];
  assign is_write = (we != 4'd0);
  assign access   = (state == S_IDLE) && (re || is_write);
  assign hit      = valid_q[cur_idx] && (tag_q[cur_idx] == cur_tag);
  assign cur_word = data_q[cur_idx][{cur_off, 5'd0} +: 32];
  assign unused_addr_bits = ^addr[1:0];

  // Replace the byte lanes selected by be in word off of a line.
  function automatic logic [127:0] merge_word(input logic [127:0] line, input logic [1:0] off,
                                              input logic [31:0] d, input logic [3:0] be);
    logic [127:0] r;
    r = line;
    for (int b = 0; b < 4; b++) begin
      if (be[b]) r[int'(off) * 32 + b * 8 +: 8] = d[b * 8 +: 8];
    end
    return r;
  endfunction

  assign refill_line = (req_we != 4'd0) ? merge_word(mem_resp_data, req_off, req_din, req_we)
                                        : mem_resp_data;

  assign stall         = (state != S_IDLE);
  assign mem_req_valid = (state == S_WB) || (state == S_RF);
  assign mem_req_rw    = (state == S_WB);
  // Victim address comes from the stored tag; the array is frozen outside IDLE/WAIT,
  // so these outputs stay stable while waiting for ready.
  assign mem_req_addr  = (state == S_WB) ? {tag_q[req_idx], req_idx} : req_line;
  assign mem_req_data  = data_q[req_idx];

  // Control state, valid/dirty bits, dout and counters.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_IDLE;
      valid_q    <= '0;
      dirty_q    <= '0;
      dout       <= '0;
      hit_count  <= '0;
      miss_count <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (access) begin
            if (hit) begin
              hit_count <= hit_count + 32'd1;
              // With re and we together, dout sees the word before the store.
              if (re) dout <= cur_word;
              if (is_write) dirty_q[cur_idx] <= 1'b1;
            end else begin
              miss_count <= miss_count + 32'd1;
              state      <= (valid_q[cur_idx] && dirty_q[cur_idx]) ? S_WB : S_RF;
            end
          end
        end
        S_WB: if (mem_req_ready) state <= S_RF;
        S_RF: if (mem_req_ready) state <= S_WAIT;
        S_WAIT: begin
          if (mem_resp_valid) begin
            valid_q[req_idx] <= 1'b1;
            dirty_q[req_idx] <= (req_we != 4'd0);
            if (req_re) dout <= mem_resp_data[{req_off, 5'd0} +: 32];
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Tag/data arrays and request registers carry no reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (access && hit && is_write) begin
        data_q[cur_idx] <= merge_word(data_q[cur_idx], cur_off, din, we);
      end
      if ((state == S_WAIT) && mem_resp_valid) begin
        data_q[req_idx] <= refill_line;
        tag_q[req_idx]  <= req_tag;
      end
    end
    if (access && !hit) begin
      req_line <= addr[31:4];
      req_off  <= cur_off;
      req_din  <= din;
      req_we   <= we;
      req_re   <= re;
    end
  end

endmodule

// File: tb/tb_dcache_direct.sv
`timescale 1ns/1ps
// tb_dcache_direct: randomized and directed checks of dcache_direct against a
// word-level memory image plus a residency map of which line sits in each set.
module tb_dcache_direct;
  localparam int LINES = 16;

  logic         clk = 1'b0;
  logic         reset;
  logic [31:0]  addr, din;
  logic         re;
  logic [3:0]   we;
  logic [31:0]  dout;
  logic         stall;
  logic         mem_req_valid, mem_req_ready, mem_req_rw;
  logic [27:0]  mem_req_addr;
  logic [127:0] mem_req_data;
  logic         mem_resp_valid;
  logic [127:0] mem_resp_data;
  logic [31:0]  hit_count, miss_count;

  dcache_direct #(.LINES(LINES)) dut (
    .clk(clk), .reset(reset), .addr(addr), .din(din), .re(re), .we(we),
    .dout(dout), .stall(stall),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_rw(mem_req_rw),
    .mem_req_addr(mem_req_addr), .mem_req_data(mem_req_data),
    .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data),
    .hit_count(hit_count), .miss_count(miss_count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Backing memory (line granularity) and the CPU-visible word image.
  logic [127:0] mem [logic [27:0]];
  logic [31:0]  img [logic [29:0]];
  logic [27:0]  res_line  [LINES];
  bit           res_valid [LINES];
  bit           res_dirty [LINES];
  logic [31:0]  exp_dout;
  logic [31:0]  exp_hits, exp_misses;

  function automatic logic [127:0] mem_line(input logic [27:0] la);
    logic [127:0] l;
    if (mem.exists(la)) return mem[la];
    for (int k = 0; k < 4; k++) l[k*32 +: 32] = {la[23:0], 8'(k)} ^ 32'h5EED0000;
    return l;
  endfunction

  function automatic logic [31:0] get_word(input logic [29:0] wa);
    logic [127:0] l;
    if (img.exists(wa)) return img[wa];
    l = mem_line(wa[29:2]);
    return l[int'(wa[1:0])*32 +: 32];
  endfunction

  task automatic model_reset();
    img.delete();
    for (int i = 0; i < LINES; i++) begin
      res_valid[i] = 0;
      res_dirty[i] = 0;
    end
    exp_dout = 32'd0;
    exp_hits = 32'd0;
    exp_misses = 32'd0;
  endtask

  // Acts as the memory for one miss, starting at the negedge after acceptance.
  task automatic serve_miss(input string nm, input logic expwb, input logic [27:0] wba,
                            input logic [127:0] wbd, input logic [27:0] rfa, input int hold);
    logic [28:0] snap;
    logic [31:0] hc, mc;
    if (expwb) begin
      checks++;
      if (mem_req_valid !== 1'b1 || mem_req_rw !== 1'b1 || mem_req_addr !== wba || mem_req_data !== wbd) begin
        errors++;
        $display("FAIL %s writeback: valid=%b rw=%b addr=%h data=%h, want 1 1 %h %h",
                 nm, mem_req_valid, mem_req_rw, mem_req_addr, mem_req_data, wba, wbd);
      end
      mem[wba] = mem_req_data;
      mem_req_ready = 1'b1;
      @(negedge clk);
      mem_req_ready = 1'b0;
    end
    checks++;
    if (mem_req_valid !== 1'b1 || mem_req_rw !== 1'b0 || mem_req_addr !== rfa || stall !== 1'b1) begin
      errors++;
      $display("FAIL %s refill request: valid=%b rw=%b addr=%h stall=%b, want 1 0 %h 1",
               nm, mem_req_valid, mem_req_rw, mem_req_addr, stall, rfa);
    end
    snap = {mem_req_valid, mem_req_addr};
    hc = hit_count;
    mc = miss_count;
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      checks++;
      if ({mem_req_valid, mem_req_addr} !== snap || mem_req_rw !== 1'b0 || stall !== 1'b1 ||
          hit_count !== hc || miss_count !== mc) begin
        errors++;
        $display("FAIL %s hold cycle %0d: valid/addr=%h rw=%b stall=%b hits=%0d misses=%0d, want %h 0 1 %0d %0d",
                 nm, h, {mem_req_valid, mem_req_addr}, mem_req_rw, stall, hit_count, miss_count, snap, hc, mc);
      end
    end
    mem_req_ready = 1'b1;
    @(negedge clk);
    mem_req_ready = 1'b0;
    checks++;
    if (mem_req_valid !== 1'b0 || stall !== 1'b1) begin
      errors++;
      $display("FAIL %s wait phase: valid=%b stall=%b, want 0 1", nm, mem_req_valid, stall);
    end
    repeat ($urandom_range(0, 2)) @(negedge clk);
    mem_resp_valid = 1'b1;
    mem_resp_data  = mem_line(rfa);
    @(negedge clk);
    mem_resp_valid = 1'b0;
    mem_resp_data  = {$urandom, $urandom, $urandom, $urandom};
  endtask

  // One CPU request: predicts hit/miss, victim and dout from the model, then drives it.
  task automatic access(input logic [31:0] a, input logic [31:0] d, input logic [3:0] w,
                        input logic r, input int hold, input string nm);
    logic [27:0]  la, wba;
    int           ix;
    logic         hitp, expwb;
    logic [31:0]  old, mask;
    logic [127:0] wbd;
    la    = a[31:4];
    ix    = int'(la % LINES);
    hitp  = res_valid[ix] && (res_line[ix] == la);
    expwb = !hitp && res_valid[ix] && res_dirty[ix];
    wba   = res_line[ix];
    for (int k = 0; k < 4; k++) wbd[k*32 +: 32] = get_word({wba, 2'(k)});
    old  = get_word(a[31:2]);
    mask = {{8{w[3]}}, {8{w[2]}}, {8{w[1]}}, {8{w[0]}}};
    if (r) exp_dout = old;
    if (w != 4'd0) img[a[31:2]] = (old & ~mask) | (d & mask);
    if (hitp) begin
      exp_hits = exp_hits + 32'd1;
      if (w != 4'd0) res_dirty[ix] = 1;
    end else begin
      exp_misses    = exp_misses + 32'd1;
      res_valid[ix] = 1;
      res_line[ix]  = la;
      res_dirty[ix] = (w != 4'd0);
    end
    addr = a; din = d; we = w; re = r;
    @(negedge clk);
    checks++;
    if (stall !== !hitp) begin
      errors++;
      $display("FAIL %s stall after accept: got %b want %b", nm, stall, !hitp);
    end
    if (!hitp) serve_miss(nm, expwb, wba, wbd, la, hold);
    re = 1'b0;
    we = 4'd0;
    checks++;
    if (stall !== 1'b0 || dout !== exp_dout) begin
      errors++;
      $display("FAIL %s dout: stall=%b dout=%h, want 0 %h", nm, stall, dout, exp_dout);
    end
    checks++;
    if (hit_count !== exp_hits || miss_count !== exp_misses) begin
      errors++;
      $display("FAIL %s counters: hits=%0d misses=%0d, want %0d %0d", nm, hit_count, miss_count, exp_hits, exp_misses);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    addr = 32'd0; din = 32'd0; re = 1'b0; we = 4'd0;
    mem_req_ready = 1'b0; mem_resp_valid = 1'b0; mem_resp_data = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    model_reset();
    checks++;
    if (dout !== 32'd0 || stall !== 1'b0 || mem_req_valid !== 1'b0 || hit_count !== 32'd0 || miss_count !== 32'd0) begin
      errors++;
      $display("FAIL reset_state: dout=%h stall=%b valid=%b hits=%0d misses=%0d, want 0 0 0 0 0",
               dout, stall, mem_req_valid, hit_count, miss_count);
    end
  endtask

  task automatic test_read_miss_hit();
    access(32'h100, 32'd0, 4'd0, 1'b1, 0, "read_miss_0x100");
    checks++;
    if (dout !== 32'h11 || miss_count !== 32'd1) begin
      errors++;
      $display("FAIL first_miss_value: dout=%h misses=%0d, want 00000011 1", dout, miss_count);
    end
    access(32'h104, 32'd0, 4'd0, 1'b1, 0, "read_hit_0x104");
    checks++;
    if (dout !== 32'h22 || hit_count !== 32'd1) begin
      errors++;
      $display("FAIL first_hit_value: dout=%h hits=%0d, want 00000022 1", dout, hit_count);
    end
  endtask

  task automatic test_write_hit();
    access(32'h108, 32'hAABBCCDD, 4'b0101, 1'b0, 0, "write_hit_0x108");
    access(32'h108, 32'd0, 4'd0, 1'b1, 0, "read_back_0x108");
    checks++;
    if (dout !== 32'h00BB00DD) begin
      errors++;
      $display("FAIL byte_merge: dout=%h want 00bb00dd", dout);
    end
  endtask

  task automatic test_conflict_wb();
    logic [127:0] l;
    access(32'h100 + 32'(16 * LINES), 32'd0, 4'd0, 1'b1, 1, "conflict_miss");
    l = mem_line(28'h10);
    checks++;
    if (l[95:64] !== 32'h00BB00DD) begin
      errors++;
      $display("FAIL writeback_payload: word2=%h want 00bb00dd", l[95:64]);
    end
  endtask

  task automatic test_ready_hold();
    access(32'h1040, 32'd0, 4'd0, 1'b1, 5, "ready_hold");
  endtask

  task automatic test_reset_mid_miss();
    addr = 32'h300; din = 32'd0; re = 1'b1; we = 4'd0;
    @(negedge clk);
    checks++;
    if (stall !== 1'b1 || mem_req_valid !== 1'b1 || mem_req_rw !== 1'b0 || mem_req_addr !== 28'h30) begin
      errors++;
      $display("FAIL midmiss_request: stall=%b valid=%b rw=%b addr=%h, want 1 1 0 0000030",
               stall, mem_req_valid, mem_req_rw, mem_req_addr);
    end
    mem_req_ready = 1'b1;
    @(negedge clk);
    mem_req_ready = 1'b0;
    re = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    checks++;
    if (stall !== 1'b0 || mem_req_valid !== 1'b0 || dout !== 32'd0 || hit_count !== 32'd0 || miss_count !== 32'd0) begin
      errors++;
      $display("FAIL midmiss_reset: stall=%b valid=%b dout=%h hits=%0d misses=%0d, want 0 0 0 0 0",
               stall, mem_req_valid, dout, hit_count, miss_count);
    end
    mem_resp_valid = 1'b1;
    mem_resp_data  = mem_line(28'h30);
    @(negedge clk);
    mem_resp_valid = 1'b0;
    access(32'h300, 32'd0, 4'd0, 1'b1, 0, "reread_after_reset");
    checks++;
    if (miss_count !== 32'd1 || hit_count !== 32'd0) begin
      errors++;
      $display("FAIL reread_misses: hits=%0d misses=%0d, want 0 1", hit_count, miss_count);
    end
  endtask

  task automatic test_write_miss();
    logic [127:0] orig, l;
    orig = mem_line(28'h20);
    access(32'h200, 32'h5A000000, 4'b1000, 1'b0, 0, "write_miss_0x200");
    access(32'h200 + 32'(16 * LINES), 32'd0, 4'd0, 1'b1, 0, "evict_dirty_0x200");
    l = mem_line(28'h20);
    checks++;
    if (l !== {orig[127:32], 8'h5A, orig[23:0]}) begin
      errors++;
      $display("FAIL write_miss_writeback: line=%h want %h", l, {orig[127:32], 8'h5A, orig[23:0]});
    end
  endtask

  task automatic test_stray_resp();
    mem_resp_valid = 1'b1;
    mem_resp_data  = {4{32'hDEADBEEF}};
    @(negedge clk);
    mem_resp_valid = 1'b0;
    checks++;
    if (stall !== 1'b0 || mem_req_valid !== 1'b0) begin
      errors++;
      $display("FAIL stray_resp_idle: stall=%b valid=%b, want 0 0", stall, mem_req_valid);
    end
    access(32'h304, 32'd0, 4'd0, 1'b1, 0, "read_after_stray");
  endtask

  task automatic test_back_to_back();
    access(32'h300, 32'h12345678, 4'b1111, 1'b1, 0, "b2b_rw");
    access(32'h304, 32'hCAFEF00D, 4'b0011, 1'b0, 0, "b2b_w");
    access(32'h304, 32'd0, 4'd0, 1'b1, 0, "b2b_r1");
    access(32'h300, 32'd0, 4'd0, 1'b1, 0, "b2b_r2");
    access(32'h30C, 32'd0, 4'd0, 1'b1, 0, "b2b_r3");
  endtask

  task automatic test_random();
    logic [31:0] a;
    logic [3:0]  w;
    logic        r;
    for (int i = 0; i < 200; i++) begin
      a = {4'd0, 24'h400 + 24'($urandom_range(0, 47)), 2'($urandom_range(0, 3)), 2'b00};
      w = ($urandom_range(0, 1) == 1) ? 4'($urandom_range(1, 15)) : 4'd0;
      r = (w == 4'd0) ? 1'b1 : 1'($urandom_range(0, 1));
      access(a, $urandom, w, r, $urandom_range(0, 2), "random");
    end
  endtask

  initial begin
    mem[28'h10] = {32'h44, 32'h33, 32'h22, 32'h11};
    test_reset();
    test_read_miss_hit();
    test_write_hit();
    test_conflict_wb();
    test_ready_hold();
    test_reset_mid_miss();
    test_write_miss();
    test_stray_resp();
    test_back_to_back();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
